// File: rtl/memory_arbiter.sv
// Shares one memory port between the instruction-fetch (imem) and load/store (dmem) ports,
// with a watchdog abort. Define ARB_ROUND_ROBIN_EN for round-robin selection instead of dmem > imem.
module memory_arbiter #(
  parameter int unsigned MAX_WAIT  = 16,
  parameter int unsigned WAIT_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready,
  output logic        arb_error
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;
  typedef enum logic {PORT_IMEM, PORT_DMEM} port_e;

  state_e               state_q, state_d;
  port_e                owner_q, owner_d;
  logic [WAIT_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic                 i_full_q, i_full_d;
  logic [31:0]          i_addr_q, i_addr_d;
  logic                 d_full_q, d_full_d;
  logic [31:0]          d_addr_q, d_addr_d;
  logic [31:0]          d_wdata_q, d_wdata_d;
  logic [3:0]           d_wstrb_q, d_wstrb_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_instr_q, mem_instr_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic [3:0]           mem_wstrb_q, mem_wstrb_d;
`ifdef ARB_ROUND_ROBIN_EN
  port_e                last_grant_q, last_grant_d;
`endif

  logic  busy, timeout, done, i_done, d_done;
  logic  i_accept, d_accept, i_elig, d_elig, issue;
  port_e grant;

  always_comb begin
    busy     = (state_q == S_WAIT);
    timeout  = busy && !memory_ready && (wait_cnt_q == WAIT_BITS'(MAX_WAIT));
    done     = busy && (memory_ready || timeout);
    i_done   = done && (owner_q == PORT_IMEM);
    d_done   = done && (owner_q == PORT_DMEM);
    // A buffer that completes this cycle can take a new pulse, and that pulse
    // (or a captured-but-unissued entry) is eligible for issue right away.
    i_accept = imem_valid && (!i_full_q || i_done);
    d_accept = dmem_valid && (!d_full_q || d_done);
    i_elig   = (i_full_q && !(busy && owner_q == PORT_IMEM)) || i_accept;
    d_elig   = (d_full_q && !(busy && owner_q == PORT_DMEM)) || d_accept;
    issue    = (!busy || done) && (i_elig || d_elig);
`ifdef ARB_ROUND_ROBIN_EN
    if (i_elig && d_elig) grant = (last_grant_q == PORT_DMEM) ? PORT_IMEM : PORT_DMEM;
    else                  grant = d_elig ? PORT_DMEM : PORT_IMEM;
`else
    grant    = d_elig ? PORT_DMEM : PORT_IMEM;
`endif

    state_d     = state_q;
    owner_d     = owner_q;
    wait_cnt_d  = wait_cnt_q;
    i_full_d    = (i_full_q && !i_done) || i_accept;
    i_addr_d    = i_accept ? imem_addr : i_addr_q;
    d_full_d    = (d_full_q && !d_done) || d_accept;
    d_addr_d    = d_accept ? dmem_addr : d_addr_q;
    d_wdata_d   = d_accept ? dmem_wdata : d_wdata_q;
    d_wstrb_d   = d_accept ? dmem_wstrb : d_wstrb_q;
    mem_valid_d = 1'b0;
    mem_instr_d = mem_instr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    if (busy) wait_cnt_d = wait_cnt_q + 1'b1;
    if (done) begin
      state_d    = S_IDLE;
      wait_cnt_d = '0;
    end
    if (issue) begin
      state_d     = S_WAIT;
      owner_d     = grant;
      wait_cnt_d  = '0;
      mem_valid_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d = grant;
`endif
      if (grant == PORT_DMEM) begin
        mem_instr_d = 1'b0;
        mem_addr_d  = d_accept ? dmem_addr  : d_addr_q;
        mem_wdata_d = d_accept ? dmem_wdata : d_wdata_q;
        mem_wstrb_d = d_accept ? dmem_wstrb : d_wstrb_q;
      end else begin
        mem_instr_d = 1'b1;
        mem_addr_d  = i_accept ? imem_addr : i_addr_q;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= PORT_IMEM;
      wait_cnt_q  <= '0;
      i_full_q    <= 1'b0;
      i_addr_q    <= '0;
      d_full_q    <= 1'b0;
      d_addr_q    <= '0;
      d_wdata_q   <= '0;
      d_wstrb_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= PORT_IMEM;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      i_full_q    <= i_full_d;
      i_addr_q    <= i_addr_d;
      d_full_q    <= d_full_d;
      d_addr_q    <= d_addr_d;
      d_wdata_q   <= d_wdata_d;
      d_wstrb_q   <= d_wstrb_d;
      mem_valid_q <= mem_valid_d;
      mem_instr_q <= mem_instr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign memory_valid = mem_valid_q;
  assign memory_instr = mem_instr_q;
  assign memory_addr  = mem_addr_q;
  assign memory_wdata = mem_wdata_q;
  assign memory_wstrb = mem_wstrb_q;
  assign arb_error    = timeout;
  assign imem_ready   = i_done;
  assign dmem_ready   = d_done;
  assign imem_rdata   = (i_done && memory_ready) ? memory_rdata : '0;
  assign dmem_rdata   = (d_done && memory_ready) ? memory_rdata : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (default fixed-priority build).
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        memory_valid;
  logic        memory_instr;
  logic [31:0] memory_addr;
  logic [31:0] memory_wdata;
  logic [3:0]  memory_wstrb;
  logic [31:0] memory_rdata;
  logic        memory_ready;
  logic        arb_error;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  memory_arbiter #(.MAX_WAIT(16), .WAIT_BITS(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_valid   (imem_valid),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .dmem_valid   (dmem_valid),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wstrb   (dmem_wstrb),
    .dmem_rdata   (dmem_rdata),
    .dmem_ready   (dmem_ready),
    .memory_valid (memory_valid),
    .memory_instr (memory_instr),
    .memory_addr  (memory_addr),
    .memory_wdata (memory_wdata),
    .memory_wstrb (memory_wstrb),
    .memory_rdata (memory_rdata),
    .memory_ready (memory_ready),
    .arb_error    (arb_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    imem_valid   = 1'b0;
    dmem_valid   = 1'b0;
    memory_ready = 1'b0;
    memory_rdata = 32'hCAFE_F00D;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; imem_valid = 1'b0; imem_addr = '0; dmem_valid = 1'b0; dmem_addr = '0;
    dmem_wdata = '0; dmem_wstrb = '0; memory_rdata = '0; memory_ready = 1'b0;
    next_cycle(); next_cycle();
    sample();
    check("rst_mvalid", {31'b0, memory_valid}, 32'd0);
    check("rst_maddr", memory_addr, 32'd0);
    check("rst_readies", {30'b0, imem_ready, dmem_ready}, 32'd0);
    check("rst_err", {31'b0, arb_error}, 32'd0);
    check("rst_instr_wstrb", {27'b0, memory_instr, memory_wstrb}, 32'd0);
    next_cycle(); rst = 1'b0;

    // Single fetch
    imem_valid = 1'b1; imem_addr = 32'h100;
    sample(); check("fetch_t_mvalid", {31'b0, memory_valid}, 32'd0);
    next_cycle(); sample();
    check("fetch_mvalid", {31'b0, memory_valid}, 32'd1);
    check("fetch_instr", {31'b0, memory_instr}, 32'd1);
    check("fetch_addr", memory_addr, 32'h100);
    check("fetch_wstrb", {28'b0, memory_wstrb}, 32'd0);
    check("fetch_early_ready", {31'b0, imem_ready}, 32'd0);
    next_cycle(); memory_ready = 1'b1; memory_rdata = 32'hDEAD_BEEF; sample();
    check("fetch_iready", {31'b0, imem_ready}, 32'd1);
    check("fetch_irdata", imem_rdata, 32'hDEAD_BEEF);
    check("fetch_dready", {31'b0, dmem_ready}, 32'd0);
    check("fetch_drdata", dmem_rdata, 32'd0);
    check("fetch_mvalid_drop", {31'b0, memory_valid}, 32'd0);

    // Collision: dmem store wins, imem follows
    next_cycle();
    imem_valid = 1'b1; imem_addr = 32'h200;
    dmem_valid = 1'b1; dmem_addr = 32'h300; dmem_wdata = 32'h1234_5678; dmem_wstrb = 4'hF;
    next_cycle(); sample();
    check("col_mvalid1", {31'b0, memory_valid}, 32'd1);
    check("col_instr1", {31'b0, memory_instr}, 32'd0);
    check("col_addr1", memory_addr, 32'h300);
    check("col_wdata1", memory_wdata, 32'h1234_5678);
    check("col_wstrb1", {28'b0, memory_wstrb}, 32'hF);
    next_cycle(); memory_ready = 1'b1; memory_rdata = 32'hAAAA_0001; sample();
    check("col_dready", {31'b0, dmem_ready}, 32'd1);
    check("col_drdata", dmem_rdata, 32'hAAAA_0001);
    check("col_iready_early", {31'b0, imem_ready}, 32'd0);
    check("col_irdata_gated", imem_rdata, 32'd0);
    next_cycle(); sample();
    check("col_mvalid2", {31'b0, memory_valid}, 32'd1);
    check("col_instr2", {31'b0, memory_instr}, 32'd1);
    check("col_addr2", memory_addr, 32'h200);
    check("col_wstrb2", {28'b0, memory_wstrb}, 32'd0);
    next_cycle(); memory_ready = 1'b1; memory_rdata = 32'hBBBB_0002; sample();
    check("col_iready", {31'b0, imem_ready}, 32'd1);
    check("col_irdata", imem_rdata, 32'hBBBB_0002);
    check("col_dready_none", {31'b0, dmem_ready}, 32'd0);

    // Back-to-back: dmem load at t, imem at t+1
    next_cycle(); dmem_valid = 1'b1; dmem_addr = 32'h400; dmem_wstrb = 4'h0;
    next_cycle(); imem_valid = 1'b1; imem_addr = 32'h500; sample();
    check("b2b_mvalid1", {31'b0, memory_valid}, 32'd1);
    check("b2b_addr1", memory_addr, 32'h400);
    check("b2b_wstrb1", {28'b0, memory_wstrb}, 32'd0);
    next_cycle(); memory_ready = 1'b1; memory_rdata = 32'h1111_1111; sample();
    check("b2b_dready", {31'b0, dmem_ready}, 32'd1);
    check("b2b_drdata", dmem_rdata, 32'h1111_1111);
    next_cycle(); sample();
    check("b2b_mvalid2", {31'b0, memory_valid}, 32'd1);
    check("b2b_addr2", memory_addr, 32'h500);
    check("b2b_instr2", {31'b0, memory_instr}, 32'd1);
    next_cycle(); memory_ready = 1'b1; memory_rdata = 32'h2222_2222; sample();
    check("b2b_iready", {31'b0, imem_ready}, 32'd1);
    check("b2b_irdata", imem_rdata, 32'h2222_2222);

    // Protocol violation: second fetch pulse while in flight is dropped
    next_cycle(); imem_valid = 1'b1; imem_addr = 32'h700;
    next_cycle(); imem_valid = 1'b1; imem_addr = 32'h704; sample();
    check("pv_mvalid", {31'b0, memory_valid}, 32'd1);
    check("pv_addr", memory_addr, 32'h700);
    next_cycle(); memory_ready = 1'b1; memory_rdata = 32'h7777_0000; sample();
    check("pv_iready", {31'b0, imem_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); sample();
      check("pv_no_mvalid", {31'b0, memory_valid}, 32'd0);
      check("pv_no_iready", {31'b0, imem_ready}, 32'd0);
    end

    // Watchdog abort on a dmem load
    next_cycle(); dmem_valid = 1'b1; dmem_addr = 32'h800; dmem_wstrb = 4'h0;
    next_cycle(); sample();
    check("wd_mvalid", {31'b0, memory_valid}, 32'd1);
    for (int k = 1; k < 16; k++) begin
      next_cycle(); sample();
      check("wd_err_early", {31'b0, arb_error}, 32'd0);
      check("wd_dready_early", {31'b0, dmem_ready}, 32'd0);
    end
    next_cycle(); sample();
    check("wd_err", {31'b0, arb_error}, 32'd1);
    check("wd_dready", {31'b0, dmem_ready}, 32'd1);
    check("wd_drdata", dmem_rdata, 32'd0);
    next_cycle(); memory_ready = 1'b1; memory_rdata = 32'h5555_5555; sample();
    check("wd_late_dready", {31'b0, dmem_ready}, 32'd0);
    check("wd_late_iready", {31'b0, imem_ready}, 32'd0);
    check("wd_err_once", {31'b0, arb_error}, 32'd0);

    // Reset mid-WAIT
    next_cycle(); imem_valid = 1'b1; imem_addr = 32'h900;
    next_cycle(); sample();
    check("rw_mvalid", {31'b0, memory_valid}, 32'd1);
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0; memory_ready = 1'b1; memory_rdata = 32'h9999_9999; sample();
    check("rw_mvalid_clr", {31'b0, memory_valid}, 32'd0);
    check("rw_maddr_clr", memory_addr, 32'd0);
    check("rw_instr_clr", {31'b0, memory_instr}, 32'd0);
    check("rw_late_iready", {31'b0, imem_ready}, 32'd0);
    check("rw_late_irdata", imem_rdata, 32'd0);
    next_cycle(); imem_valid = 1'b1; imem_addr = 32'hA00;
    next_cycle(); sample();
    check("rw_new_mvalid", {31'b0, memory_valid}, 32'd1);
    check("rw_new_addr", memory_addr, 32'hA00);
    next_cycle(); memory_ready = 1'b1; memory_rdata = 32'h0A0A_0A0A; sample();
    check("rw_new_iready", {31'b0, imem_ready}, 32'd1);
    check("rw_new_irdata", imem_rdata, 32'h0A0A_0A0A);

    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
